// File: rtl/sim_top_core.sv
// sim_top_core
//   Simulation shell: prints a boot banner on a character UART, echoes
//   characters polled from the UART input, and prints the perf counter as
//   hex when asked to, but only while the cycle counter is inside the log
//   window.
//
// State table
//   S_BANNER | emitting "SimTop\n", one char per cycle
//   S_IDLE   | poll timer running; in_valid pulses once per POLL_INTERVAL
//   S_ECHO   | the cycle the polled char is echoed; timer held at 0
//   S_DUMP   | emitting "P=xxxxxxxx\n" from the perf snapshot
//
// Ports
//   clock                 rising-edge clock
//   reset                 synchronous reset, active-low
//   io_logCtrl_log_begin  first cycle (inclusive) of the log window
//   io_logCtrl_log_end    end cycle (exclusive) of the log window; 0 = open
//   io_logCtrl_log_level  reserved, ignored
//   io_perfInfo_clean     clear perf counter
//   io_perfInfo_dump      request a perf-counter print
//   io_uart_out_valid     one-cycle strobe: io_uart_out_ch holds a char
//   io_uart_out_ch        output character
//   io_uart_in_valid      read strobe; io_uart_in_ch is sampled this cycle
//   io_uart_in_ch         input character; 8'hFF means no data
module sim_top_core #(
  parameter int POLL_INTERVAL = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [63:0] io_logCtrl_log_begin,
  input  logic [63:0] io_logCtrl_log_end,
  input  logic [63:0] io_logCtrl_log_level,
  input  logic        io_perfInfo_clean,
  input  logic        io_perfInfo_dump,
  output logic        io_uart_out_valid,
  output logic [7:0]  io_uart_out_ch,
  output logic        io_uart_in_valid,
  input  logic [7:0]  io_uart_in_ch
);

  localparam int TW = (POLL_INTERVAL > 2) ? $clog2(POLL_INTERVAL) : 1;
  localparam logic [TW-1:0] POLL_LAST = TW'(POLL_INTERVAL - 1);
  localparam logic [3:0] BANNER_LAST = 4'd6;
  localparam logic [3:0] DUMP_LAST = 4'd10;

  typedef enum logic [1:0] {S_BANNER, S_IDLE, S_ECHO, S_DUMP} state_t;

  state_t        state, state_n;
  logic [3:0]    idx, idx_n;
  logic [TW-1:0] timer, timer_n;
  logic [63:0]   cyc;
  logic [31:0]   perf;
  logic [31:0]   snap, snap_n;
  logic          dump_pending, pending_n;
  logic          out_valid_n, in_valid_n;
  logic [7:0]    out_ch_n;

  logic          win;
  logic          take_echo;
  logic          enter_dump;
  logic [3:0]    digit_sel;
  logic [31:0]   digit_shift;
  logic [3:0]    nib;
  logic [7:0]    hex_ch;
  logic [7:0]    banner_ch;
  logic [7:0]    dump_ch;

  logic          unused_log_level;
  assign unused_log_level = ^io_logCtrl_log_level;

  assign win = (cyc >= io_logCtrl_log_begin) &&
               ((io_logCtrl_log_end == 64'd0) || (cyc < io_logCtrl_log_end));

  // in_valid is registered, so it is high exactly while timer sits at POLL_LAST
  assign take_echo  = (state == S_IDLE) && io_uart_in_valid && (io_uart_in_ch != 8'hFF);
  assign enter_dump = (state == S_IDLE) && !take_echo && dump_pending;

  // hex digits are chars 2..9, most significant nibble first
  assign digit_sel   = idx - 4'd2;
  assign digit_shift = snap << {digit_sel, 2'b00};
  assign nib         = digit_shift[31:28];
  assign hex_ch      = (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h57 + {4'h0, nib});

  always_comb begin
    banner_ch = 8'h0A;
    case (idx)
      4'd0:    banner_ch = "S";
      4'd1:    banner_ch = "i";
      4'd2:    banner_ch = "m";
      4'd3:    banner_ch = "T";
      4'd4:    banner_ch = "o";
      4'd5:    banner_ch = "p";
      default: banner_ch = 8'h0A;
    endcase
  end

  always_comb begin
    dump_ch = hex_ch;
    if (idx == 4'd0) begin
      dump_ch = "P";
    end else if (idx == 4'd1) begin
      dump_ch = "=";
    end else if (idx == DUMP_LAST) begin
      dump_ch = 8'h0A;
    end
  end

  always_comb begin
    state_n     = state;
    idx_n       = idx;
    timer_n     = timer;
    snap_n      = snap;
    out_valid_n = 1'b0;
    out_ch_n    = 8'h00;
    pending_n   = dump_pending;

    case (state)
      S_BANNER: begin
        out_valid_n = 1'b1;
        out_ch_n    = banner_ch;
        if (idx == BANNER_LAST) begin
          state_n = S_IDLE;
          idx_n   = 4'd0;
          timer_n = '0;
        end else begin
          idx_n = idx + 4'd1;
        end
      end
      S_IDLE: begin
        if (take_echo) begin
          state_n     = S_ECHO;
          out_valid_n = 1'b1;
          out_ch_n    = io_uart_in_ch;
          timer_n     = '0;
        end else if (dump_pending) begin
          state_n = S_DUMP;
          idx_n   = 4'd0;
          snap_n  = perf;
          timer_n = '0;
        end else if (timer == POLL_LAST) begin
          timer_n = '0;
        end else begin
          timer_n = timer + TW'(1);
        end
      end
      S_ECHO: begin
        state_n = S_IDLE;
        timer_n = '0;
      end
      S_DUMP: begin
        out_valid_n = 1'b1;
        out_ch_n    = dump_ch;
        if (idx == DUMP_LAST) begin
          state_n = S_IDLE;
          idx_n   = 4'd0;
          timer_n = '0;
        end else begin
          idx_n = idx + 4'd1;
        end
      end
      default: begin
        state_n = S_BANNER;
        idx_n   = 4'd0;
        timer_n = '0;
      end
    endcase

    // Requests arriving while a print is pending or running fold into it
    if (enter_dump) begin
      pending_n = 1'b0;
    end else if (io_perfInfo_dump && win && (state != S_DUMP)) begin
      pending_n = 1'b1;
    end

    in_valid_n = (state_n == S_IDLE) && (timer_n == POLL_LAST);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state             <= S_BANNER;
      idx               <= 4'd0;
      timer             <= '0;
      cyc               <= 64'd0;
      perf              <= 32'd0;
      snap              <= 32'd0;
      dump_pending      <= 1'b0;
      io_uart_out_valid <= 1'b0;
      io_uart_out_ch    <= 8'h00;
      io_uart_in_valid  <= 1'b0;
    end else begin
      state             <= state_n;
      idx               <= idx_n;
      timer             <= timer_n;
      cyc               <= cyc + 64'd1;
      perf              <= io_perfInfo_clean ? 32'd0 : perf + 32'd1;
      snap              <= snap_n;
      dump_pending      <= pending_n;
      io_uart_out_valid <= out_valid_n;
      io_uart_out_ch    <= out_ch_n;
      io_uart_in_valid  <= in_valid_n;
    end
  end

endmodule

// File: tb/tb_sim_top_core.sv
// Bench for sim_top_core: directed sequences, an echo vector table, and a
// randomized phase checked every cycle against a queue-based reference model.
module tb_sim_top_core;

  localparam int PI = 16;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [63:0] log_begin = 64'd0;
  logic [63:0] log_end = 64'd0;
  logic [63:0] log_level = 64'd0;
  logic        clean = 1'b0;
  logic        dump = 1'b0;
  logic [7:0]  in_ch = 8'hFF;
  logic        out_valid;
  logic [7:0]  out_ch;
  logic        in_valid;

  sim_top_core #(.POLL_INTERVAL(PI)) dut (
    .clock                (clock),
    .reset                (reset),
    .io_logCtrl_log_begin (log_begin),
    .io_logCtrl_log_end   (log_end),
    .io_logCtrl_log_level (log_level),
    .io_perfInfo_clean    (clean),
    .io_perfInfo_dump     (dump),
    .io_uart_out_valid    (out_valid),
    .io_uart_out_ch       (out_ch),
    .io_uart_in_valid     (in_valid),
    .io_uart_in_ch        (in_ch)
  );

  always #5 clock = ~clock;

  int pass_cnt = 0;
  int total_cnt = 0;
  int tick_no = 0;

  logic [7:0] got_q[$];
  int         got_t[$];
  int         iv_t[$];

  // Reference model: a queue of chars still to print, plus echo hold and timer
  logic [7:0]      m_q[$];
  bit              m_busy, m_dumping, m_hold, m_pend, m_ov, m_iv;
  bit              m_win, m_was_dump, m_enter;
  logic [7:0]      m_ch;
  longint unsigned m_cyc;
  int unsigned     m_perf;
  int              m_timer;
  string           m_s;

  always @(posedge clock) begin
    if (!reset) begin
      m_q.delete();
      m_s = "SimTop\n";
      for (int k = 0; k < m_s.len(); k++) m_q.push_back(m_s[k]);
      m_busy = 1; m_dumping = 0; m_hold = 0; m_pend = 0;
      m_ov = 0; m_iv = 0; m_ch = 8'h00;
      m_cyc = 0; m_perf = 0; m_timer = 0;
    end else begin
      m_win = (m_cyc >= log_begin) && (log_end == 64'd0 || m_cyc < log_end);
      m_was_dump = m_dumping;
      m_enter = 0;
      m_ov = 0;
      if (m_busy) begin
        m_ov = 1;
        m_ch = m_q.pop_front();
        if (m_q.size() == 0) begin
          m_busy = 0; m_dumping = 0; m_timer = 0;
        end
      end else if (m_hold) begin
        m_hold = 0; m_timer = 0;
      end else if (m_timer == PI - 1 && in_ch != 8'hFF) begin
        m_ov = 1; m_ch = in_ch; m_hold = 1;
      end else if (m_pend) begin
        m_enter = 1;
        m_s = $sformatf("P=%08x\n", m_perf);
        for (int k = 0; k < m_s.len(); k++) m_q.push_back(m_s[k]);
        m_busy = 1; m_dumping = 1; m_timer = 0;
      end else begin
        m_timer = (m_timer + 1) % PI;
      end
      if (m_enter) m_pend = 0;
      else if (dump && m_win && !m_was_dump) m_pend = 1;
      m_iv = !m_busy && !m_hold && (m_timer == PI - 1);
      m_cyc = m_cyc + 1;
      m_perf = clean ? 0 : m_perf + 1;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h (tick %0d)", name, act, exp, tick_no);
  endtask

  task automatic chk_str(input string name, input string act, input string exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got [%s] expected [%s]", name, act, exp);
  endtask

  function automatic string got_str();
    string s = "";
    foreach (got_q[i]) s = $sformatf("%s%c", s, got_q[i]);
    return s;
  endfunction

  task automatic clear_obs();
    got_q.delete(); got_t.delete(); iv_t.delete();
  endtask

  task automatic tick();
    @(negedge clock);
    tick_no++;
    chk("model_out_valid", {63'd0, out_valid}, {63'd0, m_ov});
    chk("model_in_valid", {63'd0, in_valid}, {63'd0, m_iv});
    if (m_ov) chk("model_out_ch", {56'd0, out_ch}, {56'd0, m_ch});
    if (out_valid === 1'b1) begin got_q.push_back(out_ch); got_t.push_back(tick_no); end
    if (in_valid === 1'b1) iv_t.push_back(tick_no);
  endtask

  task automatic wait_poll(input string name);
    int n = 0;
    do begin tick(); n++; end while (in_valid !== 1'b1 && n < 40);
    chk(name, {63'd0, in_valid}, 64'd1);
  endtask

  task automatic wait_cyc(input longint unsigned target);
    int n = 0;
    while (m_cyc != target && n < 3000) begin tick(); n++; end
    chk("reach_cyc", m_cyc, target);
  endtask

  task automatic dump_at(input longint unsigned c, input int hold, input int exp_n, input string name);
    wait_cyc(c);
    clear_obs();
    dump = 1'b1;
    repeat (hold) tick();
    dump = 1'b0;
    repeat (20) tick();
    chk(name, got_q.size(), exp_n);
  endtask

  typedef struct {
    logic [7:0] ch;
    logic       exp_v;
    logic [7:0] exp_ch;
  } vec_t;

  vec_t vecs[7];
  int   t_rel, t_echo, n;

  initial begin
    vecs[0] = '{8'hFF, 1'b0, 8'h00};
    vecs[1] = '{8'h41, 1'b1, 8'h41};
    vecs[2] = '{8'h00, 1'b1, 8'h00};
    vecs[3] = '{8'hFE, 1'b1, 8'hFE};
    vecs[4] = '{8'hFF, 1'b0, 8'h00};
    vecs[5] = '{8'h0A, 1'b1, 8'h0A};
    vecs[6] = '{8'h7F, 1'b1, 8'h7F};

    // Reset held, then banner
    repeat (5) tick();
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_in_valid", {63'd0, in_valid}, 64'd0);
    chk("rst_out_ch", {56'd0, out_ch}, 64'd0);
    reset = 1'b1;
    t_rel = tick_no;
    clear_obs();
    repeat (9) tick();
    chk_str("banner_text", got_str(), "SimTop\n");
    chk("banner_first_tick", got_t.size() > 0 ? got_t[0] : -1, t_rel + 1);
    chk("banner_last_tick", got_t.size() == 7 ? got_t[6] : -1, t_rel + 7);
    chk("banner_no_poll", iv_t.size(), 0);

    // Idle with no input data
    clear_obs();
    repeat (100) tick();
    chk("idle_no_out", got_q.size(), 0);
    chk("idle_poll_count_ok", {63'd0, iv_t.size() >= 6}, 64'd1);
    for (int i = 1; i < iv_t.size(); i++) chk("idle_poll_spacing", iv_t[i] - iv_t[i-1], PI);

    // Echo and poll restart
    wait_poll("poll_t3");
    in_ch = 8'h41;
    tick();
    chk("echo_valid", {63'd0, out_valid}, 64'd1);
    chk("echo_ch", {56'd0, out_ch}, 64'h41);
    t_echo = tick_no;
    in_ch = 8'hFF;
    wait_poll("poll_after_echo");
    chk("echo_to_poll", tick_no - t_echo, PI);

    // Echo vector table
    for (int i = 0; i < 7; i++) begin
      wait_poll("poll_vec");
      in_ch = vecs[i].ch;
      tick();
      in_ch = 8'hFF;
      chk("vec_valid", {63'd0, out_valid}, {63'd0, vecs[i].exp_v});
      if (vecs[i].exp_v) chk("vec_ch", {56'd0, out_ch}, {56'd0, vecs[i].exp_ch});
    end

    // Clean, then print after 0x2A increments
    log_begin = 64'd0; log_end = 64'd0;
    tick();
    clean = 1'b1;
    tick();
    clean = 1'b0;
    repeat (41) tick();
    clear_obs();
    dump = 1'b1;
    tick();
    dump = 1'b0;
    repeat (14) tick();
    chk_str("perf_print", got_str(), "P=0000002a\n");

    // Log window gating
    log_begin = 64'd1000; log_end = 64'd2000;
    dump_at(64'd500, 1, 0, "win_before");
    dump_at(64'd999, 1, 0, "win_edge_999");
    dump_at(64'd1500, 3, 11, "win_inside_merged");
    chk("win_inside_first", got_q.size() > 0 ? {56'd0, got_q[0]} : 64'hFFFF, 64'h50);
    dump_at(64'd2000, 1, 0, "win_end_excl");

    // Reset in the middle of a print
    log_begin = 64'd0; log_end = 64'd0;
    dump = 1'b1;
    tick();
    dump = 1'b0;
    n = 0;
    do begin tick(); n++; end while (out_valid !== 1'b1 && n < 40);
    chk("t6_in_dump", {63'd0, out_valid}, 64'd1);
    repeat (3) tick();
    reset = 1'b0;
    tick();
    chk("t6_rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("t6_rst_in_valid", {63'd0, in_valid}, 64'd0);
    chk("t6_rst_out_ch", {56'd0, out_ch}, 64'd0);
    reset = 1'b1;
    t_rel = tick_no;
    clear_obs();
    repeat (9) tick();
    chk_str("t6_banner", got_str(), "SimTop\n");
    chk("t6_banner_first", got_t.size() > 0 ? got_t[0] : -1, t_rel + 1);
    repeat (40) tick();
    chk("t6_no_leftover", got_q.size(), 7);

    // Randomized phase against the model
    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(0, 299) != 0);
      clean = ($urandom_range(0, 19) == 0);
      dump  = ($urandom_range(0, 24) == 0);
      in_ch = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'hFF;
      if ($urandom_range(0, 199) == 0) begin
        log_begin = m_cyc + 64'($urandom_range(0, 100));
        log_end = ($urandom_range(0, 1) == 0) ? 64'd0 : log_begin + 64'($urandom_range(1, 200));
      end
      tick();
    end

    reset = 1'b1; clean = 1'b0; dump = 1'b0; in_ch = 8'hFF;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", pass_cnt, total_cnt);
    $fatal(1, "watchdog");
  end

endmodule
